// File: rtl/tcb_lib_demultiplexer_pipelined_pkg.sv
// Shared TCB transfer types and bus defaults for the pipelined demultiplexer.
package tcb_lib_demultiplexer_pipelined_pkg;

  localparam int TCB_ADR = 32;
  localparam int TCB_DAT = 32;
  localparam int TCB_BYT = TCB_DAT / 8;
  localparam int TCB_DLY = 1;

  typedef struct packed {
    logic               lck;
    logic               wen;
    logic [TCB_ADR-1:0] adr;
    logic [1:0]         siz;
    logic [TCB_BYT-1:0] byt;
    logic [TCB_DAT-1:0] wdt;
  } tcb_req_t;

  typedef struct packed {
    logic err;
  } tcb_sts_t;

  typedef struct packed {
    logic [TCB_DAT-1:0] rdt;
    tcb_sts_t           sts;
  } tcb_rsp_t;

  typedef enum logic {
    LCK_IDLE   = 1'b0,
    LCK_LOCKED = 1'b1
  } tcb_lck_e;

endpackage

// File: rtl/tcb_lib_decoder.sv
// Address decoder: lowest-index pattern/mask match wins, miss when nothing matches.
module tcb_lib_decoder #(
  parameter int                      IFN = 3,
  parameter int                      IFL = $clog2(IFN),
  parameter int                      ADR = 32,
  parameter logic [IFN-1:0][ADR-1:0] DAM = '0,
  parameter logic [IFN-1:0][ADR-1:0] DMK = '0
)(
  input  logic [ADR-1:0] adr,
  output logic [IFL-1:0] sel,
  output logic           miss
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    sel  = '0;
    miss = 1'b1;
    for (int i = IFN-1; i >= 0; i--) begin
      if ((adr & DMK[i]) == (DAM[i] & DMK[i])) begin
        sel  = IFL'(i);
        miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tcb_lib_error_responder.sv
// Always-ready TCB subordinate that answers every transfer with rdt=0, sts.err=1 after DLY cycles.
module tcb_lib_error_responder
  import tcb_lib_demultiplexer_pipelined_pkg::*;
#(
  parameter int DLY = TCB_DLY
)(
  input  logic     clk,
  input  logic     rst,
  input  logic     vld,
  output logic     rdy,
  output tcb_rsp_t rsp
);

  logic err_dly;

  assign rdy         = 1'b1;
  assign rsp.rdt     = '0;
  assign rsp.sts.err = err_dly;

  if (DLY == 0) begin : g_comb
    assign err_dly = vld;
  end else begin : g_pipe
    logic [DLY-1:0] vld_p;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= '0;
      end else begin
        for (int i = DLY-1; i >= 1; i--) vld_p[i] <= vld_p[i-1];
        vld_p[0] <= vld;
      end
    end
    assign err_dly = vld_p[DLY-1];
  end

endmodule

// File: rtl/tcb_lib_demultiplexer_pipelined.sv
// TCB demultiplexer with built-in decoder, in-flight select pipeline, lock tracking and error reporting.
module tcb_lib_demultiplexer_pipelined
  import tcb_lib_demultiplexer_pipelined_pkg::*;
#(
  parameter int                      IFN = 3,
  parameter int                      IFL = $clog2(IFN),
  parameter int                      ADR = TCB_ADR,
  parameter int                      DLY = TCB_DLY,
  parameter logic [IFN-1:0][ADR-1:0] DAM = {32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [IFN-1:0][ADR-1:0] DMK = {32'h0002_0000, 32'h0003_0000, 32'h0003_0000},
  parameter bit                      ERR = 1'b1,
  parameter int                      CNW = 16
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sub_vld,
  input  tcb_req_t              sub_req,
  output logic                  sub_rdy,
  output tcb_rsp_t              sub_rsp,
  output logic     [IFN-1:0]    man_vld,
  output tcb_req_t [IFN-1:0]    man_req,
  input  logic     [IFN-1:0]    man_rdy,
  input  tcb_rsp_t [IFN-1:0]    man_rsp,
  output logic                  dec_err,
  output logic     [CNW-1:0]    err_cnt,
  output logic                  busy
);

  typedef struct packed {
    logic           vld;
    logic           err;
    logic [IFL-1:0] sel;
  } tcb_dmx_stage_t;

  logic [IFL-1:0] dec_sel;
  logic [IFL-1:0] sel;
  logic           miss;
  logic           lckerr;
  logic           err;
  logic           trn;
  logic           erp_rdy;
  tcb_rsp_t       erp_rsp;
  tcb_lck_e       lck_state;
  logic [IFL-1:0] lck_idx;
  tcb_dmx_stage_t stg_p0;
  tcb_dmx_stage_t stg_out;

  tcb_lib_decoder #(
    .IFN (IFN),
    .IFL (IFL),
    .ADR (ADR),
    .DAM (DAM),
    .DMK (DMK)
  ) u_dec (
    .adr  (sub_req.adr[ADR-1:0]),
    .sel  (dec_sel),
    .miss (miss)
  );

  // Without the error responder, unmapped addresses fall through to the last port.
  assign sel    = (miss && !ERR) ? IFL'(IFN-1) : dec_sel;
  assign lckerr = (lck_state == LCK_LOCKED) && !(miss && ERR) && (sel != lck_idx);
  assign err    = (miss && ERR) || lckerr;

  assign sub_rdy = err ? erp_rdy : man_rdy[sel];
  assign trn     = sub_vld && sub_rdy;

  always_comb begin
    man_vld = '0;
    man_req = '0;
    for (int i = 0; i < IFN; i++) begin
      man_req[i] = sub_req;
      man_vld[i] = sub_vld && !err && !rst && (sel == IFL'(i));
    end
  end

  tcb_lib_error_responder #(
    .DLY (DLY)
  ) u_erp (
    .clk (clk),
    .rst (rst),
    .vld (stg_p0.err),
    .rdy (erp_rdy),
    .rsp (erp_rsp)
  );

  // Stage 0: transfer captured combinationally.
  assign stg_p0 = '{vld: trn, err: trn && err, sel: sel};

  // Stages 1..DLY: registered select history, stage DLY steers the response.
  if (DLY == 0) begin : g_comb
    assign stg_out = stg_p0;
    assign busy    = 1'b0;
  end else begin : g_pipe
    tcb_dmx_stage_t stg_p [1:DLY];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 1; i <= DLY; i++) stg_p[i] <= '0;
      end else begin
        for (int i = DLY; i >= 2; i--) stg_p[i] <= stg_p[i-1];
        stg_p[1] <= stg_p0;
      end
    end
    always_comb begin
      busy = 1'b0;
      for (int i = 1; i <= DLY; i++) busy = busy | stg_p[i].vld;
    end
    assign stg_out = stg_p[DLY];
  end

  assign sub_rsp = stg_out.err ? erp_rsp : man_rsp[stg_out.sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lck_state <= LCK_IDLE;
      lck_idx   <= '0;
    end else if (trn && !err) begin
      case (lck_state)
        LCK_IDLE: begin
          if (sub_req.lck) begin
            lck_state <= LCK_LOCKED;
            lck_idx   <= sel;
          end
        end
        LCK_LOCKED: begin
          if (!sub_req.lck) lck_state <= LCK_IDLE;
        end
        default: lck_state <= LCK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      dec_err <= trn && err;
      if (trn && err && (err_cnt != '1)) err_cnt <= err_cnt + CNW'(1);
    end
  end

endmodule

// File: tb/tb_tcb_lib_demultiplexer_pipelined.sv
// Directed bench: a 3-port DLY=1 demux and a 2-port DLY=2, CNW=2 demux with simple memory subordinates.
module tb_tcb_lib_demultiplexer_pipelined;
  import tcb_lib_demultiplexer_pipelined_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                a_sub_vld, a_sub_rdy, a_dec_err, a_busy;
  tcb_req_t            a_sub_req;
  tcb_rsp_t            a_sub_rsp;
  logic     [2:0]      a_man_vld;
  tcb_req_t [2:0]      a_man_req;
  logic     [2:0]      a_man_rdy;
  tcb_rsp_t [2:0]      a_man_rsp;
  logic     [15:0]     a_err_cnt;

  logic                b_sub_vld, b_sub_rdy, b_dec_err, b_busy;
  tcb_req_t            b_sub_req;
  tcb_rsp_t            b_sub_rsp;
  logic     [1:0]      b_man_vld;
  tcb_req_t [1:0]      b_man_req;
  logic     [1:0]      b_man_rdy;
  tcb_rsp_t [1:0]      b_man_rsp;
  logic     [1:0]      b_err_cnt;

  assign a_man_rdy = '1;
  assign b_man_rdy = '1;

  tcb_lib_demultiplexer_pipelined #(
    .IFN (3), .DLY (1), .ERR (1'b1), .CNW (16),
    .DAM ({32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
    .DMK ({32'h0002_0000, 32'h0003_0000, 32'h0003_0000})
  ) dut_a (
    .clk (clk), .rst (rst),
    .sub_vld (a_sub_vld), .sub_req (a_sub_req), .sub_rdy (a_sub_rdy), .sub_rsp (a_sub_rsp),
    .man_vld (a_man_vld), .man_req (a_man_req), .man_rdy (a_man_rdy), .man_rsp (a_man_rsp),
    .dec_err (a_dec_err), .err_cnt (a_err_cnt), .busy (a_busy)
  );

  tcb_lib_demultiplexer_pipelined #(
    .IFN (2), .DLY (2), .ERR (1'b1), .CNW (2),
    .DAM ({32'h0001_0000, 32'h0000_0000}),
    .DMK ({32'h0003_0000, 32'h0003_0000})
  ) dut_b (
    .clk (clk), .rst (rst),
    .sub_vld (b_sub_vld), .sub_req (b_sub_req), .sub_rdy (b_sub_rdy), .sub_rsp (b_sub_rsp),
    .man_vld (b_man_vld), .man_req (b_man_req), .man_rdy (b_man_rdy), .man_rsp (b_man_rsp),
    .dec_err (b_dec_err), .err_cnt (b_err_cnt), .busy (b_busy)
  );

  // Subordinate models: word memories, DLY=1 for A, DLY=2 for B, preset while rst is high.
  logic [31:0] a_mem [3][64];
  tcb_rsp_t    a_rsp_q [3];
  int          a_cnt [3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int w = 0; w < 64; w++) a_mem[i][w] <= 32'hA000_0000 | (32'(i) << 16) | 32'(w);
        a_rsp_q[i] <= '0;
        a_cnt[i]   <= 0;
      end else if (a_man_vld[i] && a_man_rdy[i]) begin
        a_cnt[i] <= a_cnt[i] + 1;
        if (a_man_req[i].wen) begin
          a_mem[i][a_man_req[i].adr[7:2]] <= a_man_req[i].wdt;
          a_rsp_q[i] <= '0;
        end else begin
          a_rsp_q[i] <= '{rdt: a_mem[i][a_man_req[i].adr[7:2]], sts: '{err: 1'b0}};
        end
      end
    end
  end
  always_comb for (int i = 0; i < 3; i++) a_man_rsp[i] = a_rsp_q[i];

  logic [31:0] b_mem [2][64];
  tcb_rsp_t    b_rsp_q1 [2];
  tcb_rsp_t    b_rsp_q2 [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int w = 0; w < 64; w++) b_mem[i][w] <= 32'hB000_0000 | (32'(i) << 16) | 32'(w);
        b_rsp_q1[i] <= '0;
        b_rsp_q2[i] <= '0;
      end else begin
        b_rsp_q2[i] <= b_rsp_q1[i];
        if (b_man_vld[i] && b_man_rdy[i]) begin
          if (b_man_req[i].wen) begin
            b_mem[i][b_man_req[i].adr[7:2]] <= b_man_req[i].wdt;
            b_rsp_q1[i] <= '0;
          end else begin
            b_rsp_q1[i] <= '{rdt: b_mem[i][b_man_req[i].adr[7:2]], sts: '{err: 1'b0}};
          end
        end
      end
    end
  end
  always_comb for (int i = 0; i < 2; i++) b_man_rsp[i] = b_rsp_q2[i];

  typedef struct {
    logic        lck;
    logic        wen;
    logic [31:0] adr;
    logic [31:0] wdt;
    int          sel;   // expected man port, -1 for none
    logic        err;
    logic [31:0] rdt;
  } vec_t;

  vec_t tbl [16];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   a_cnt0 [3];
  int   a_exp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic a_drive(input logic lck, input logic wen, input logic [31:0] adr, input logic [31:0] wdt);
    a_sub_req     = '0;
    a_sub_req.lck = lck;
    a_sub_req.wen = wen;
    a_sub_req.adr = adr;
    a_sub_req.siz = 2'd2;
    a_sub_req.byt = '1;
    a_sub_req.wdt = wdt;
    a_sub_vld     = 1'b1;
  endtask

  task automatic b_drive(input logic lck, input logic wen, input logic [31:0] adr, input logic [31:0] wdt);
    b_sub_req     = '0;
    b_sub_req.lck = lck;
    b_sub_req.wen = wen;
    b_sub_req.adr = adr;
    b_sub_req.siz = 2'd2;
    b_sub_req.byt = '1;
    b_sub_req.wdt = wdt;
    b_sub_vld     = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ev;
    rst = 1'b1;
    a_sub_vld = 1'b0; a_sub_req = '0;
    b_sub_vld = 1'b0; b_sub_req = '0;

    for (int i = 0; i < 3; i++) begin
      tbl[4*i+0] = '{1'b0, 1'b1, 32'(i) << 16,            32'h7654_3210, i, 1'b0, 32'h0};
      tbl[4*i+1] = '{1'b0, 1'b1, (32'(i) << 16) | 32'h20, 32'hfedc_ba98, i, 1'b0, 32'h0};
      tbl[4*i+2] = '{1'b0, 1'b0, 32'(i) << 16,            32'h0,         i, 1'b0, 32'h7654_3210};
      tbl[4*i+3] = '{1'b0, 1'b0, (32'(i) << 16) | 32'h20, 32'h0,         i, 1'b0, 32'hfedc_ba98};
    end
    tbl[12] = '{1'b1, 1'b1, 32'h0001_0000, 32'h1111_1111,  1, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 32'h0000_0000, 32'h2222_2222, -1, 1'b1, 32'h0};
    tbl[14] = '{1'b0, 1'b1, 32'h0001_0000, 32'h3333_3333,  1, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 1'b1, 32'h0000_0000, 32'h4444_4444,  0, 1'b0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst a_busy",    32'(a_busy),    32'd0);
    chk("rst a_dec_err", 32'(a_dec_err), 32'd0);
    chk("rst a_err_cnt", 32'(a_err_cnt), 32'd0);
    chk("rst a_man_vld", 32'(a_man_vld), 32'd0);
    chk("rst b_busy",    32'(b_busy),    32'd0);
    chk("rst b_err_cnt", 32'(b_err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back reads to subs 0, 1, 2.
    @(negedge clk);
    a_drive(1'b0, 1'b0, 32'h0000_0000, 32'h0);
    #1;
    chk("b2b rdy0", 32'(a_sub_rdy), 32'd1);
    chk("b2b vld0", 32'(a_man_vld), 32'b001);
    @(posedge clk); #1;
    chk("b2b rsp0",  a_sub_rsp.rdt,  32'hA000_0000);
    chk("b2b busy0", 32'(a_busy),    32'd1);
    a_drive(1'b0, 1'b0, 32'h0001_0000, 32'h0);
    #1;
    chk("b2b rdy1", 32'(a_sub_rdy), 32'd1);
    chk("b2b vld1", 32'(a_man_vld), 32'b010);
    @(posedge clk); #1;
    chk("b2b rsp1",  a_sub_rsp.rdt,  32'hA001_0000);
    chk("b2b busy1", 32'(a_busy),    32'd1);
    a_drive(1'b0, 1'b0, 32'h0002_0000, 32'h0);
    #1;
    chk("b2b vld2", 32'(a_man_vld), 32'b100);
    @(posedge clk); #1;
    chk("b2b rsp2",  a_sub_rsp.rdt,  32'hA002_0000);
    chk("b2b err2",  32'(a_sub_rsp.sts.err), 32'd0);
    chk("b2b busy2", 32'(a_busy),    32'd1);
    a_sub_vld = 1'b0;
    @(posedge clk); #1;
    chk("b2b idle busy", 32'(a_busy), 32'd0);

    // Table: write/read each sub, then the lock sequence.
    for (int i = 0; i < 3; i++) a_cnt0[i] = a_cnt[i];
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a_drive(tbl[k].lck, tbl[k].wen, tbl[k].adr, tbl[k].wdt);
      ev = (tbl[k].sel < 0) ? 3'b000 : 3'(1 << tbl[k].sel);
      #1;
      chk($sformatf("vec%0d man_vld", k), 32'(a_man_vld), 32'(ev));
      chk($sformatf("vec%0d rdy", k),     32'(a_sub_rdy), 32'd1);
      @(posedge clk); #1;
      a_sub_vld = 1'b0;
      if (tbl[k].err) a_exp_cnt++;
      chk($sformatf("vec%0d rdt", k),     a_sub_rsp.rdt,              tbl[k].rdt);
      chk($sformatf("vec%0d sts", k),     32'(a_sub_rsp.sts.err),     32'(tbl[k].err));
      chk($sformatf("vec%0d dec_err", k), 32'(a_dec_err),             32'(tbl[k].err));
      chk($sformatf("vec%0d err_cnt", k), 32'(a_err_cnt),             32'(a_exp_cnt));
      if (k == 11)
        for (int i = 0; i < 3; i++)
          chk($sformatf("count man%0d", i), 32'(a_cnt[i] - a_cnt0[i]), 32'd4);
    end

    // Unmapped read on the 2-port, DLY=2 instance.
    @(negedge clk);
    b_drive(1'b0, 1'b0, 32'h0002_0000, 32'h0);
    #1;
    chk("unm man_vld", 32'(b_man_vld), 32'd0);
    chk("unm rdy",     32'(b_sub_rdy), 32'd1);
    @(posedge clk); #1;
    b_sub_vld = 1'b0;
    chk("unm dec_err", 32'(b_dec_err), 32'd1);
    chk("unm err_cnt", 32'(b_err_cnt), 32'd1);
    chk("unm busy",    32'(b_busy),    32'd1);
    @(posedge clk); #1;
    chk("unm sts",       32'(b_sub_rsp.sts.err), 32'd1);
    chk("unm rdt",       b_sub_rsp.rdt,          32'd0);
    chk("unm dec_err lo", 32'(b_dec_err),        32'd0);
    @(posedge clk); #1;
    chk("unm busy lo", 32'(b_busy), 32'd0);

    // Five more unmapped transfers saturate the 2-bit counter.
    @(negedge clk);
    b_drive(1'b0, 1'b0, 32'h0003_0000, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat%0d dec_err", k), 32'(b_dec_err), 32'd1);
      chk($sformatf("sat%0d err_cnt", k), 32'(b_err_cnt), (k + 2 > 3) ? 32'd3 : 32'(k + 2));
    end
    b_sub_vld = 1'b0;
    @(posedge clk); #1;
    chk("sat hold", 32'(b_err_cnt), 32'd3);

    // Lock to sub 1, put two lock violations in flight, then reset mid-flight.
    @(negedge clk);
    b_drive(1'b1, 1'b1, 32'h0001_0000, 32'h5555_5555);
    #1;
    chk("lck man_vld", 32'(b_man_vld), 32'b10);
    @(posedge clk); #1;
    b_drive(1'b0, 1'b1, 32'h0000_0000, 32'h6666_6666);
    #1;
    chk("viol man_vld", 32'(b_man_vld), 32'd0);
    chk("viol rdy",     32'(b_sub_rdy), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("inflight busy", 32'(b_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst busy",    32'(b_busy),    32'd0);
    chk("arst err_cnt", 32'(b_err_cnt), 32'd0);
    chk("arst dec_err", 32'(b_dec_err), 32'd0);
    chk("arst man_vld", 32'(b_man_vld), 32'd0);
    @(posedge clk); #1;
    b_sub_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post rst sts0", 32'(b_sub_rsp.sts.err), 32'd0);
    @(posedge clk); #1;
    chk("post rst sts1", 32'(b_sub_rsp.sts.err), 32'd0);
    chk("post rst busy", 32'(b_busy),            32'd0);
    @(negedge clk);
    b_drive(1'b0, 1'b1, 32'h0000_0000, 32'h7777_7777);
    #1;
    chk("idle man_vld", 32'(b_man_vld), 32'b01);
    @(posedge clk); #1;
    b_sub_vld = 1'b0;
    chk("idle dec_err", 32'(b_dec_err), 32'd0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tcb_lib_demultiplexer_pipelined.md
Name: tcb_lib_demultiplexer_pipelined

Overview:
- Next-generation TCB demultiplexer with the address decoder built in: one manager-facing TCB port, IFN subordinate-facing TCB ports.
- Tracks up to DLY+1 in-flight transfers, so response routing follows each request's decoded target for any response delay.
- Adds an internal error responder for unmapped addresses, lock-sequence enforcement and status counters.
- Sits between a CPU/DMA manager and peripheral/memory subordinates in the interconnect.

Parameters:
- IFN, 3, number of subordinate interfaces (>=2).
- IFL, $clog2(IFN), select width.
- ADR, TCB_BUS_DEF.ADR, address width.
- DLY, TCB_HSK_DEF.DLY, fixed response delay in cycles; must equal tcb.CFG.HSK.DLY.
- DAM, logic [ADR-1:0] [IFN-1:0], address/mask patterns (x = don't care); the lowest index that matches wins.
- ERR, 1'b1, enable the internal unmapped-address error responder (0: unmapped addresses route to interface IFN-1).
- CNW, 16, width of the error counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- sub  tcb_if.sub  interface  manager-facing TCB port (request in, response out).
- man  tcb_if.man [IFN-1:0]  interface  subordinate-facing TCB ports.
- dec_err  output  1  one-cycle pulse on a transfer to an unmapped address or a lock violation.
- err_cnt  output  CNW  saturating count of dec_err pulses.
- busy  output  1  a response is still pending in the select pipeline.

Behaviour:
- Decode (combinational): sel = lowest i with sub.req.adr ==? DAM[i]. miss = no match.
- Request routing: man[sel].vld = sub.vld & ~miss & ~lckerr. All other man[*].vld = 0. Request fields are broadcast to every man port.
- Ready: sub.rdy = man[sel].rdy. On miss or lckerr with ERR=1, sub.rdy = 1 (error responder is always ready).
- Transfer: sub.vld & sub.rdy.
- Select pipeline: DLY+1 stages of {vld, err, sel}. Stage 0 captures the transfer combinationally; stages 1..DLY are registers.
  - The response mux uses stage DLY.
  - With DLY=0 it is purely combinational.
- Response routing: if stage DLY.err, then sub.rsp.rdt = 0 and sub.rsp.sts.err = 1. Otherwise sub.rsp = man[stage sel].rsp.
- Lock state machine:
  - States: IDLE, LOCKED(idx).
  - IDLE -> LOCKED(sel) on a transfer with req.lck=1 to a mapped address.
  - LOCKED -> IDLE on a transfer with req.lck=0 to idx.
  - In LOCKED, a transfer whose sel != idx is a lock violation (lckerr): error response, state unchanged.
- dec_err: registered, asserted the cycle after an erroring transfer.
- err_cnt: increments with dec_err, saturates at 2^CNW-1.
- Simultaneous error and counter at max: dec_err still pulses, counter holds.
- busy = OR of stage 1..DLY vld bits.
- Back-to-back transfers to different interfaces: no stall, each response is taken from its own stage.
- Reset (async, mid-operation allowed):
  - Pipeline vld/err cleared, sel = 0, lock state = IDLE.
  - dec_err = 0, err_cnt = 0, busy = 0.
  - All man[*].vld = 0.
  - In-flight responses are discarded.

Decomposition:
- tcb_pkg gains tcb_dmx_stage_t {vld, err, sel}. It uses IFL via a parameterised typedef in the module.
- Sub-module tcb_lib_decoder (existing) computes sel.
- New sub-module tcb_lib_error_responder: always ready, returns sts.err=1 and rdt=0 after DLY cycles. It is reused elsewhere in the codebase.

Test Plan (IFN=3, DAM {1x, 01, 00} on adr[17:16], DLY=1 unless stated):
- For i=0..2, write32 0x(i)0000=0x76543210, write32 0x(i)0020=0xfedcba98, then read both back. Required: each man[i] sees exactly 4 transfers; reads return the written values with sts.err=0.
- Back-to-back reads 0x00000000, 0x00010000, 0x00020000 in consecutive cycles. Required: responses arrive in order from subs 0, 1, 2, one per cycle, with no stall; busy=1 throughout and busy=0 the cycle after the last response.
- IFN=2, DAM {01, 00}, ERR=1, read 0x00020000. Required: no man vld; after DLY cycles sts.err=1 and rdt=0; dec_err pulses once; err_cnt=1.
- Locked write to 0x00010000 (lck=1), then a write to 0x00000000. Required: the second write gets an error response and man[0].vld is never asserted. A following write to 0x00010000 with lck=0 succeeds and returns the FSM to IDLE.
- Assert rst while DLY=2 with 2 transfers in flight. Required: busy=0, err_cnt=0, lock state IDLE; no stale responses appear after rst is released.
- CNW=2, 5 unmapped transfers. Required: err_cnt saturates at 3.
